// File: rtl/sig_event_monitor_pkg.sv
// Shared types and helpers for the multi-channel signal event monitor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sig_event_monitor_pkg;

    // Per-channel check mode, two bits per channel on the mode bus
    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_STABLE   = 2'b01,
        MODE_RISE_WIN = 2'b10,
        MODE_MIN_HOLD = 2'b11
    } mode_e;

    // Channel FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PRIME = 2'b01,
        S_RUN   = 2'b10,
        S_ARMED = 2'b11
    } ch_state_e;

    // Widest saturating counter the helper below can describe
    localparam int SAT_W_MAX = 32;

    // All-ones ceiling of a w-bit saturating counter
    function automatic logic [SAT_W_MAX-1:0] sat_limit(input int w);
        if (w >= SAT_W_MAX) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/event_mon_ch.sv
// One monitor channel: edge detect plus STABLE / RISE_WIN / MIN_HOLD check.
// Latency: rose/fell/pass/viol registered, 1 cycle after the sampling edge.
// Backpressure: none; observes every cycle and never stalls.
module event_mon_ch
    import sig_event_monitor_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int WIN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             sig_i,
    input  logic [1:0]       mode_i,
    input  logic             arm_i,
    input  logic [WIN_W-1:0] win_i,
    input  logic             clear_i,
    output logic             rose_o,
    output logic             fell_o,
    output logic             pass_o,
    output logic             viol_o,
    output logic             viol_sticky_o,
    output logic [CNT_W-1:0] viol_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    mode_e            mode_cur;
    mode_e            mode_q;
    ch_state_e        state_q, state_d;
    logic             prev_q, prev_d;
    logic [WIN_W-1:0] tmr_q, tmr_d;
    logic             rose_d, fell_d, pass_d, viol_d;
    logic             rise, fall, any_edge;

    assign mode_cur = mode_e'(mode_i);
    assign rise     = sig_i & ~prev_q;
    assign fall     = ~sig_i & prev_q;
    assign any_edge = rise | fall;

    // Next state, prev sample, window/hold timer and pulse decisions
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        tmr_d   = tmr_q;
        rose_d  = 1'b0;
        fell_d  = 1'b0;
        pass_d  = 1'b0;
        viol_d  = 1'b0;
        if (!enable_i || mode_cur == MODE_OFF) begin
            // Going quiet forgets the last sample and any open window
            state_d = S_IDLE;
            prev_d  = 1'b0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PRIME;
                end
                S_PRIME: begin
                    // First sample has nothing to compare against
                    prev_d  = sig_i;
                    state_d = S_RUN;
                end
                S_RUN, S_ARMED: begin
                    prev_d = sig_i;
                    rose_d = rise;
                    fell_d = fall;
                    if (mode_cur != mode_q) begin
                        // New mode starts clean next cycle; this cycle checks nothing
                        state_d = S_RUN;
                        tmr_d   = '0;
                    end else begin
                        case (mode_cur)
                            MODE_STABLE: begin
                                viol_d = any_edge;
                            end
                            MODE_RISE_WIN: begin
                                if (state_q == S_RUN) begin
                                    if (arm_i) begin
                                        tmr_d   = (win_i == '0) ? WIN_ONE : win_i;
                                        state_d = S_ARMED;
                                    end
                                end else if (rise) begin
                                    pass_d  = 1'b1;
                                    state_d = S_RUN;
                                    tmr_d   = '0;
                                end else if (tmr_q <= WIN_ONE) begin
                                    viol_d  = 1'b1;
                                    state_d = S_RUN;
                                    tmr_d   = '0;
                                end else begin
                                    tmr_d = tmr_q - WIN_ONE;
                                end
                            end
                            MODE_MIN_HOLD: begin
                                if (any_edge) begin
                                    // A zero hold length turns the check off
                                    viol_d = (tmr_q != '0) && (win_i != '0);
                                    tmr_d  = win_i;
                                end else if (tmr_q != '0) begin
                                    tmr_d = tmr_q - WIN_ONE;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM, sample and timer registers plus registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_OFF;
            prev_q  <= 1'b0;
            tmr_q   <= '0;
            rose_o  <= 1'b0;
            fell_o  <= 1'b0;
            pass_o  <= 1'b0;
            viol_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_cur;
            prev_q  <= prev_d;
            tmr_q   <= tmr_d;
            rose_o  <= rose_d;
            fell_o  <= fell_d;
            pass_o  <= pass_d;
            viol_o  <= viol_d;
        end
    end

    // Sticky flag and saturating count; a violation beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_sticky_o <= 1'b0;
            viol_cnt_o    <= '0;
        end else if (viol_d) begin
            viol_sticky_o <= 1'b1;
            if (clear_i) begin
                viol_cnt_o <= CNT_ONE;
            end else if (viol_cnt_o != CNT_MAX) begin
                viol_cnt_o <= viol_cnt_o + CNT_ONE;
            end
        end else if (clear_i) begin
            viol_sticky_o <= 1'b0;
            viol_cnt_o    <= '0;
        end
    end

endmodule

// File: rtl/sig_event_monitor.sv
// Multi-channel hardware assertion engine: edge pulses and per-channel checks.
// Latency: all outputs registered, 1 cycle after the sampling edge.
// Backpressure: none; every channel observes its signal every cycle.
module sig_event_monitor
    import sig_event_monitor_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [NUM_CH-1:0]       sig_i,
    input  logic [2*NUM_CH-1:0]     mode_i,
    input  logic [NUM_CH-1:0]       arm_i,
    input  logic [WIN_W-1:0]        win_i,
    input  logic                    clear_i,
    output logic [NUM_CH-1:0]       rose_o,
    output logic [NUM_CH-1:0]       fell_o,
    output logic [NUM_CH-1:0]       pass_o,
    output logic [NUM_CH-1:0]       viol_o,
    output logic [NUM_CH-1:0]       viol_sticky_o,
    output logic [NUM_CH*CNT_W-1:0] viol_cnt_o
);

    // One independent channel per monitored signal, slices packed by index
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        event_mon_ch #(
            .CNT_W (CNT_W),
            .WIN_W (WIN_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable_i      (enable_i),
            .sig_i         (sig_i[c]),
            .mode_i        (mode_i[2*c +: 2]),
            .arm_i         (arm_i[c]),
            .win_i         (win_i),
            .clear_i       (clear_i),
            .rose_o        (rose_o[c]),
            .fell_o        (fell_o[c]),
            .pass_o        (pass_o[c]),
            .viol_o        (viol_o[c]),
            .viol_sticky_o (viol_sticky_o[c]),
            .viol_cnt_o    (viol_cnt_o[CNT_W*c +: CNT_W])
        );
    end

endmodule

// File: tb/tb_sig_event_monitor.sv
// Bench for sig_event_monitor: directed scenarios plus random traffic.
// Expected outputs come from a timestamp-based reference model via a scoreboard.
// A monitor process compares DUT outputs against queued expectations every cycle.
module tb_sig_event_monitor;

    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int WW  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable_i = 1'b0;
    logic [NCH-1:0]  sig_i = '0;
    logic [2*NCH-1:0] mode_i = '0;
    logic [NCH-1:0]  arm_i = '0;
    logic [WW-1:0]   win_i = '0;
    logic            clear_i = 1'b0;
    logic [NCH-1:0]  rose_o, fell_o, pass_o, viol_o, viol_sticky_o;
    logic [NCH*CW-1:0] viol_cnt_o;

    typedef struct packed {
        logic [NCH-1:0]    rose;
        logic [NCH-1:0]    fell;
        logic [NCH-1:0]    pass;
        logic [NCH-1:0]    viol;
        logic [NCH-1:0]    sticky;
        logic [NCH*CW-1:0] cnt;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } exp_t;

    exp_t sb_q[$];
    out_t dut_out;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    assign dut_out = {rose_o, fell_o, pass_o, viol_o, viol_sticky_o, viol_cnt_o};

    sig_event_monitor #(.NUM_CH(NCH), .CNT_W(CW), .WIN_W(WW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .sig_i         (sig_i),
        .mode_i        (mode_i),
        .arm_i         (arm_i),
        .win_i         (win_i),
        .clear_i       (clear_i),
        .rose_o        (rose_o),
        .fell_o        (fell_o),
        .pass_o        (pass_o),
        .viol_o        (viol_o),
        .viol_sticky_o (viol_sticky_o),
        .viol_cnt_o    (viol_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model (timestamps, not counters) ----------------
    int tnow;
    int active_len [NCH];   // consecutive enabled cycles, capped at 3
    bit last_smp   [NCH];
    int last_mode  [NCH];
    bit armed      [NCH];
    int deadline   [NCH];   // cycle at which an unmet window fails
    bit hold_vld   [NCH];
    int hold_edge  [NCH];   // cycle of the last edge
    int hold_len   [NCH];   // hold length in force since that edge
    int vcnt       [NCH];
    bit vsticky    [NCH];

    task automatic model_reset();
        tnow = 0;
        for (int c = 0; c < NCH; c++) begin
            active_len[c] = 0; last_smp[c] = 0; last_mode[c] = 0;
            armed[c] = 0; deadline[c] = 0;
            hold_vld[c] = 0; hold_edge[c] = 0; hold_len[c] = 0;
            vcnt[c] = 0; vsticky[c] = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic [NCH-1:0] s,
                              input logic [2*NCH-1:0] m_v, input logic [NCH-1:0] a,
                              input logic [WW-1:0] w, input logic clr, output out_t e);
        int  m;
        int  wl;
        bit  r, f, p, v;
        e = '0;
        tnow++;
        wl = int'(w);
        for (int c = 0; c < NCH; c++) begin
            m = int'(m_v[2*c +: 2]);
            r = 0; f = 0; p = 0; v = 0;
            if (!en || m == 0) begin
                active_len[c] = 0;
                armed[c] = 0;
                hold_vld[c] = 0;
            end else begin
                if (active_len[c] < 3) active_len[c]++;
                if (active_len[c] >= 3) begin
                    r = s[c] && !last_smp[c];
                    f = !s[c] && last_smp[c];
                    if (m != last_mode[c]) begin
                        armed[c] = 0;
                        hold_vld[c] = 0;
                    end else if (m == 1) begin
                        v = r || f;
                    end else if (m == 2) begin
                        if (armed[c]) begin
                            if (r) begin
                                p = 1; armed[c] = 0;
                            end else if (tnow == deadline[c]) begin
                                v = 1; armed[c] = 0;
                            end
                        end else if (a[c]) begin
                            armed[c] = 1;
                            deadline[c] = tnow + ((wl == 0) ? 1 : wl);
                        end
                    end else begin
                        if (r || f) begin
                            v = hold_vld[c] && (tnow - hold_edge[c] <= hold_len[c]) && (wl != 0);
                            hold_vld[c] = 1;
                            hold_edge[c] = tnow;
                            hold_len[c] = wl;
                        end
                    end
                end
                last_smp[c] = s[c];
            end
            last_mode[c] = m;
            if (v) begin
                vsticky[c] = 1;
                vcnt[c] = clr ? 1 : ((vcnt[c] + 1 > 3) ? 3 : vcnt[c] + 1);
            end else if (clr) begin
                vsticky[c] = 0;
                vcnt[c] = 0;
            end
            e.rose[c] = r;
            e.fell[c] = f;
            e.pass[c] = p;
            e.viol[c] = v;
            e.sticky[c] = vsticky[c];
            e.cnt[CW*c +: CW] = CW'(vcnt[c]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the model's answer, return at posedge+1
    task automatic step(input logic en, input logic [NCH-1:0] s, input logic [2*NCH-1:0] m,
                        input logic [NCH-1:0] a, input logic [WW-1:0] w, input logic clr);
        out_t e;
        exp_t x;
        enable_i = en; sig_i = s; mode_i = m; arm_i = a; win_i = w; clear_i = clr;
        model_step(en, s, m, a, w, clr, e);
        x.cyc = edge_cnt + 1;
        x.o = e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sb_q.size() > 0 && sb_q[0].cyc < edge_cnt) begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL sb_stale: cycle %0d never compared (now %0d)", mon_e.cyc, edge_cnt);
                end
                if (sb_q.size() > 0 && sb_q[0].cyc == edge_cnt) begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (dut_out !== mon_e.o) begin
                        errors++;
                        $display("FAIL sb_cycle_%0d: got %h expected %h", edge_cnt, dut_out, mon_e.o);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    localparam logic [7:0] M_A = 8'b00_00_00_01;  // ch0 STABLE
    localparam logic [7:0] M_B = 8'b00_00_10_01;  // + ch1 RISE_WIN
    localparam logic [7:0] M_C = 8'b00_11_10_01;  // + ch2 MIN_HOLD

    initial begin
        logic [NCH-1:0]   s_r;
        logic [2*NCH-1:0] m_r;
        logic [NCH-1:0]   a_r;
        logic [WW-1:0]    w_r;
        model_reset();
        #1;
        chk("reset_rose", rose_o, 0);
        chk("reset_viol", viol_o, 0);
        chk("reset_cnt", viol_cnt_o, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // STABLE: sig held high from reset, priming hides the 0->1 difference
        for (int i = 0; i < 4; i++) begin
            step(1, 4'b0001, M_A, 0, 0, 0);
            chk("stable_prime_rose0", rose_o[0], 0);
            chk("stable_prime_viol0", viol_o[0], 0);
        end
        step(1, 4'b0000, M_A, 0, 0, 0);
        chk("stable_fell0", fell_o[0], 1);
        chk("stable_viol0", viol_o[0], 1);
        chk("stable_cnt0", viol_cnt_o[1:0], 1);

        // RISE_WIN on ch1, window 3: rise inside window passes
        repeat (3) step(1, 4'b0000, M_B, 0, 3, 0);
        step(1, 4'b0000, M_B, 4'b0010, 3, 0);
        step(1, 4'b0000, M_B, 0, 3, 0);
        step(1, 4'b0010, M_B, 0, 3, 0);
        chk("win_pass1", pass_o[1], 1);
        chk("win_nopass_viol1", viol_o[1], 0);
        // re-arm with no rise: violation on the third cycle after arming
        step(1, 4'b0010, M_B, 4'b0010, 3, 0);
        step(1, 4'b0010, M_B, 0, 3, 0);
        chk("win_early1_a", viol_o[1], 0);
        step(1, 4'b0010, M_B, 0, 3, 0);
        chk("win_early1_b", viol_o[1], 0);
        step(1, 4'b0010, M_B, 0, 3, 0);
        chk("win_expire_viol1", viol_o[1], 1);
        chk("win_expire_sticky1", viol_sticky_o[1], 1);

        // MIN_HOLD on ch2, hold 4: edges two apart violate, far apart do not
        repeat (3) step(1, 4'b0010, M_C, 0, 4, 0);
        step(1, 4'b0110, M_C, 0, 4, 0);
        step(1, 4'b0110, M_C, 0, 4, 0);
        step(1, 4'b0010, M_C, 0, 4, 0);
        chk("hold_viol2", viol_o[2], 1);
        repeat (7) step(1, 4'b0010, M_C, 0, 4, 0);
        step(1, 4'b0110, M_C, 0, 4, 0);
        chk("hold_ok_viol2", viol_o[2], 0);
        chk("hold_ok_rose2", rose_o[2], 1);

        // Saturation of a 2-bit count, then clear colliding with a violation
        for (int i = 0; i < 6; i++) step(1, (i % 2 == 0) ? 4'b0111 : 4'b0110, M_C, 0, 4, 0);
        chk("sat_cnt0", viol_cnt_o[1:0], 3);
        step(1, 4'b0111, M_C, 0, 4, 1);
        chk("clr_vs_viol_cnt0", viol_cnt_o[1:0], 1);
        chk("clr_vs_viol_sticky0", viol_sticky_o[0], 1);
        chk("clr_sticky1", viol_sticky_o[1], 0);

        // Reset while ch1 window is open
        step(1, 4'b0101, M_C, 0, 4, 0);
        step(1, 4'b0101, M_C, 4'b0010, 4, 0);
        step(1, 4'b0101, M_C, 0, 4, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt", viol_cnt_o, 0);
        chk("arst_sticky", viol_sticky_o, 0);
        chk("arst_pulses", {rose_o, fell_o, pass_o, viol_o}, 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1, (i < 4) ? 4'b0000 : 4'b0010, M_C, 0, 4, 0);
            chk("arst_no_pass1", pass_o[1], 0);
            chk("arst_no_viol1", viol_o[1], 0);
        end

        // Enable dropped for one cycle while ch0 changes
        step(1, 4'b0010, M_A, 0, 4, 0);
        step(0, 4'b0011, M_A, 0, 4, 0);
        chk("en_off_rose0", rose_o[0], 0);
        step(1, 4'b0011, M_A, 0, 4, 0);
        chk("en_idle_rose0", rose_o[0], 0);
        step(1, 4'b0010, M_A, 0, 4, 0);
        chk("en_prime_fell0", fell_o[0], 0);
        step(1, 4'b0011, M_A, 0, 4, 0);
        chk("en_resume_rose0", rose_o[0], 1);

        // Random traffic against the model
        s_r = sig_i;
        m_r = 8'($urandom());
        w_r = 4'($urandom_range(0, 6));
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) s_r[c] = ~s_r[c];
                a_r[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0) m_r = 8'($urandom());
            if ($urandom_range(0, 19) == 0) w_r = 4'($urandom_range(0, 6));
            step(($urandom_range(0, 49) != 0), s_r, m_r, a_r, w_r, ($urandom_range(0, 39) == 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
